// File: rtl/gpu_ram_arbiter_pkg.sv
// Shared definitions for the GPU RAM arbiter: op encodings, port IDs and the read-return tag.
package gpu_ram_arbiter_pkg;

    typedef enum logic [1:0] {
        OpNone = 2'd0,
        OpWr   = 2'd1,
        OpRd   = 2'd2
    } op_e;

    localparam logic PortA = 1'b0;
    localparam logic PortB = 1'b1;

    typedef struct packed {
        logic valid;
        logic port;
        logic oor;
    } tag_t;

endpackage

// File: rtl/gpu_ram_port_hold.sv
// One-deep hold for a host port: captures a strobe, holds the op until granted, tracks dropped strobes.
module gpu_ram_port_hold
    import gpu_ram_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_BITS = 20
) (
    input  logic                 GPU_CLK,
    input  logic                 reset,
    input  logic                 wr_ena,
    input  logic                 rd_req,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [7:0]           wdata,
    input  logic                 grant,
    output logic                 pend,
    output op_e                  op,
    output logic [ADDR_BITS-1:0] hold_addr,
    output logic [7:0]           hold_wdata,
    output logic                 err
);

    logic                 pend_q, pend_d;
    op_e                  op_q, op_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic [7:0]           wdata_q, wdata_d;
    logic                 err_q, err_d;

    always_comb begin
        pend_d  = pend_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        if (grant) begin
            pend_d = 1'b0;
        end
        // A strobe is only accepted into an empty slot; grant and capture never coincide.
        if (wr_ena || rd_req) begin
            if (pend_q) begin
                err_d = 1'b1;
            end else begin
                pend_d  = 1'b1;
                op_d    = wr_ena ? OpWr : OpRd;
                addr_d  = addr;
                wdata_d = wdata;
                if (wr_ena && rd_req) begin
                    err_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge GPU_CLK or posedge reset) begin
        if (reset) begin
            pend_q  <= 1'b0;
            op_q    <= OpNone;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            pend_q  <= pend_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
        end
    end

    assign pend       = pend_q;
    assign op         = op_q;
    assign hold_addr  = addr_q;
    assign hold_wdata = wdata_q;
    assign err        = err_q;

endmodule

// File: rtl/gpu_ram_arbiter.sv
// Round-robin arbiter sharing the GPU RAM port between the Z80 bridge (A) and the blitter (B).
module gpu_ram_arbiter
    import gpu_ram_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_BITS     = 20,
    parameter int unsigned MEM_SIZE_BITS = 15,
    parameter int unsigned READ_LATENCY  = 2
) (
    input  logic                 GPU_CLK,
    input  logic                 reset,
    input  logic                 a_wr_ena,
    input  logic                 a_rd_req,
    input  logic [ADDR_BITS-1:0] a_addr,
    input  logic [7:0]           a_wdata,
    output logic [7:0]           a_rData,
    output logic                 a_rd_rdy,
    output logic                 a_busy,
    output logic                 a_err,
    input  logic                 b_wr_ena,
    input  logic                 b_rd_req,
    input  logic [ADDR_BITS-1:0] b_addr,
    input  logic [7:0]           b_wdata,
    output logic [7:0]           b_rData,
    output logic                 b_rd_rdy,
    output logic                 b_busy,
    output logic                 b_err,
    output logic [ADDR_BITS-1:0] ram_addr,
    output logic [7:0]           ram_wdata,
    output logic                 ram_we,
    output logic                 ram_rd,
    input  logic [7:0]           ram_rdata
);

    logic                 a_pend, b_pend, grant_a, grant_b;
    op_e                  a_op, b_op, sel_op;
    logic [ADDR_BITS-1:0] a_haddr, b_haddr, sel_addr;
    logic [7:0]           a_hwdata, b_hwdata, sel_wdata;
    logic                 sel_port, oor;

    gpu_ram_port_hold #(.ADDR_BITS(ADDR_BITS)) u_hold_a (
        .GPU_CLK    (GPU_CLK),
        .reset      (reset),
        .wr_ena     (a_wr_ena),
        .rd_req     (a_rd_req),
        .addr       (a_addr),
        .wdata      (a_wdata),
        .grant      (grant_a),
        .pend       (a_pend),
        .op         (a_op),
        .hold_addr  (a_haddr),
        .hold_wdata (a_hwdata),
        .err        (a_err)
    );

    gpu_ram_port_hold #(.ADDR_BITS(ADDR_BITS)) u_hold_b (
        .GPU_CLK    (GPU_CLK),
        .reset      (reset),
        .wr_ena     (b_wr_ena),
        .rd_req     (b_rd_req),
        .addr       (b_addr),
        .wdata      (b_wdata),
        .grant      (grant_b),
        .pend       (b_pend),
        .op         (b_op),
        .hold_addr  (b_haddr),
        .hold_wdata (b_hwdata),
        .err        (b_err)
    );

    assign a_busy = a_pend;
    assign b_busy = b_pend;

    logic                 last_grant_q, last_grant_d;
    logic                 ram_we_q, ram_we_d, ram_rd_q, ram_rd_d;
    logic [ADDR_BITS-1:0] ram_addr_q, ram_addr_d;
    logic [7:0]           ram_wdata_q, ram_wdata_d;
    tag_t                 tag_q [0:READ_LATENCY];
    tag_t                 tag_d, ret_tag;
    logic [7:0]           a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d, ret_data;
    logic                 a_rdy_q, a_rdy_d, b_rdy_q, b_rdy_d;

    // On a tie the port that did not win last time goes first.
    assign grant_a   = a_pend && (!b_pend || (last_grant_q == PortB));
    assign grant_b   = b_pend && (!a_pend || (last_grant_q == PortA));
    assign sel_port  = grant_b ? PortB : PortA;
    assign sel_op    = grant_b ? b_op : a_op;
    assign sel_addr  = grant_b ? b_haddr : a_haddr;
    assign sel_wdata = grant_b ? b_hwdata : a_hwdata;
    assign oor       = |(sel_addr >> MEM_SIZE_BITS);

    assign ret_tag  = tag_q[READ_LATENCY];
    assign ret_data = ret_tag.oor ? 8'hFF : ram_rdata;

    always_comb begin
        last_grant_d = last_grant_q;
        ram_we_d     = 1'b0;
        ram_rd_d     = 1'b0;
        ram_addr_d   = ram_addr_q;
        ram_wdata_d  = ram_wdata_q;
        tag_d        = '0;
        if (grant_a || grant_b) begin
            last_grant_d = sel_port;
            ram_addr_d   = sel_addr;
            ram_wdata_d  = sel_wdata;
            if (sel_op == OpWr) begin
                ram_we_d = !oor;
            end else begin
                // Out-of-range reads still carry a tag so the requester gets 8'hFF in order.
                ram_rd_d = !oor;
                tag_d    = '{valid: 1'b1, port: sel_port, oor: oor};
            end
        end
        a_rdy_d   = ret_tag.valid && (ret_tag.port == PortA);
        b_rdy_d   = ret_tag.valid && (ret_tag.port == PortB);
        a_rdata_d = a_rdy_d ? ret_data : a_rdata_q;
        b_rdata_d = b_rdy_d ? ret_data : b_rdata_q;
    end

    always_ff @(posedge GPU_CLK or posedge reset) begin
        if (reset) begin
            last_grant_q <= PortB;
            ram_we_q     <= 1'b0;
            ram_rd_q     <= 1'b0;
            ram_addr_q   <= '0;
            ram_wdata_q  <= '0;
            a_rdata_q    <= '0;
            b_rdata_q    <= '0;
            a_rdy_q      <= 1'b0;
            b_rdy_q      <= 1'b0;
            for (int i = 0; i <= int'(READ_LATENCY); i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            last_grant_q <= last_grant_d;
            ram_we_q     <= ram_we_d;
            ram_rd_q     <= ram_rd_d;
            ram_addr_q   <= ram_addr_d;
            ram_wdata_q  <= ram_wdata_d;
            a_rdata_q    <= a_rdata_d;
            b_rdata_q    <= b_rdata_d;
            a_rdy_q      <= a_rdy_d;
            b_rdy_q      <= b_rdy_d;
            tag_q[0]     <= tag_d;
            for (int i = 1; i <= int'(READ_LATENCY); i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    assign ram_we    = ram_we_q;
    assign ram_rd    = ram_rd_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign a_rData   = a_rdata_q;
    assign b_rData   = b_rdata_q;
    assign a_rd_rdy  = a_rdy_q;
    assign b_rd_rdy  = b_rdy_q;

endmodule
